// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between a multi-byte block
// source and a single-byte status source. Blocks are sent MSB byte first,
// one tx_start/tx_done handshake per byte.
//
// Build option: define UART_TX_SCHED_GAP_EN to compile in the GAP state, which
// holds the line idle for GAP_TICKS s_tick pulses after every byte. Without it,
// bytes go back-to-back and s_tick is unused.
//
// Handshakes: a request is accepted in the cycle where valid & ready are both
// high. ready is combinational, only ever high in IDLE, and only for the
// requester that wins arbitration this cycle, so ready never rises without its
// own valid. Requests are not sampled outside IDLE.
module uart_tx_scheduler #(
  parameter int NBYTES    = 16,
  parameter int GAP_TICKS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                blk_valid,
  input  logic [8*NBYTES-1:0] blk_data,
  output logic                blk_ready,
  input  logic                stat_valid,
  input  logic [7:0]          stat_data,
  output logic                stat_ready,
  output logic                tx_start,
  output logic [7:0]          tx_byte,
  input  logic                tx_done,
  output logic                busy,
  output logic                blk_sent,
  output logic [1:0]          state_dbg
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_blk_q;   // 1: last grant went to the block source
  logic [W-1:0]    shreg_q;      // current byte always sits in the top 8 bits
  logic [CW-1:0]   cnt_q;        // bytes remaining after the current one
  logic            job_blk_q;    // current job came from the block source
  logic            blk_sent_q;
  logic            grant_blk, grant_stat;
  logic            byte_done;

  // Round-robin: on a tie the source that was not granted last time wins.
  assign grant_blk  = (state_q == IDLE) & blk_valid  & (~stat_valid | ~last_blk_q);
  assign grant_stat = (state_q == IDLE) & stat_valid & (~blk_valid  |  last_blk_q);
  assign byte_done  = (state_q == WAIT) & tx_done;

  assign blk_ready  = grant_blk;
  assign stat_ready = grant_stat;
  assign tx_start   = (state_q == START);
  assign tx_byte    = shreg_q[W-1 -: 8];
  assign busy       = (state_q != IDLE);
  assign blk_sent   = blk_sent_q;
  assign state_dbg  = state_q;

`ifdef UART_TX_SCHED_GAP_EN
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [GW-1:0] GAP_TERM = GW'(GAP_TICKS);

  logic [GW-1:0] gap_cnt_q;
  logic          more_q;        // bytes remain once the gap expires
  logic          gap_hit;

  assign gap_hit = (state_q == GAP) & s_tick & (gap_cnt_q == GAP_LAST);

  // Gap tick counter: cleared while waiting on the byte, saturates at GAP_TICKS.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt_q <= '0;
      more_q    <= 1'b0;
    end else begin
      if (state_q == WAIT) begin
        gap_cnt_q <= '0;
      end else if ((state_q == GAP) && s_tick && (gap_cnt_q != GAP_TERM)) begin
        gap_cnt_q <= gap_cnt_q + GW'(1);
      end
      if (byte_done) begin
        more_q <= (cnt_q != '0);
      end
    end
  end
`else
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_blk | grant_stat) begin
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
`ifdef UART_TX_SCHED_GAP_EN
          if (GAP_TICKS > 0) begin
            state_d = GAP;
          end else begin
            state_d = (cnt_q != '0) ? START : IDLE;
          end
`else
          state_d = (cnt_q != '0) ? START : IDLE;
`endif
        end
      end
`ifdef UART_TX_SCHED_GAP_EN
      GAP: begin
        if (gap_hit) begin
          state_d = more_q ? START : IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job datapath: load on grant, shift to the next byte on each non-final tx_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      job_blk_q  <= 1'b0;
      last_blk_q <= 1'b1;
    end else if (grant_blk) begin
      shreg_q    <= blk_data;
      cnt_q      <= CW'(NBYTES - 1);
      job_blk_q  <= 1'b1;
      last_blk_q <= 1'b1;
    end else if (grant_stat) begin
      shreg_q    <= W'(stat_data) << (W - 8);
      cnt_q      <= '0;
      job_blk_q  <= 1'b0;
      last_blk_q <= 1'b0;
    end else if (byte_done && (cnt_q != '0)) begin
      shreg_q    <= shreg_q << 8;
      cnt_q      <= cnt_q - CW'(1);
    end
  end

  // Block-complete pulse, one cycle after the final tx_done of a block job.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_sent_q <= 1'b0;
    end else begin
      blk_sent_q <= byte_done & (cnt_q == '0) & job_blk_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler. Inputs are driven on the falling edge and
// outputs sampled on the falling edge. Expected bytes are queued when a job is
// requested and popped on every tx_start. Works for both builds; the gap
// expectations are selected with UART_TX_SCHED_GAP_EN (GAP_TICKS=4).
module tb_uart_tx_scheduler;

  localparam int NB = 16;
  localparam int GT = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_tick = 1'b0;
  logic         blk_valid = 1'b0;
  logic [W-1:0] blk_data = '0;
  logic         blk_ready;
  logic         stat_valid = 1'b0;
  logic [7:0]   stat_data = '0;
  logic         stat_ready;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         tx_done = 1'b0;
  logic         busy;
  logic         blk_sent;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int n_start = 0;
  int n_sent = 0;
  int exp_starts = 0;

  uart_tx_scheduler #(.NBYTES(NB), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .stat_valid(stat_valid), .stat_data(stat_data), .stat_ready(stat_ready),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .blk_sent(blk_sent), .state_dbg(state_dbg)
  );

  // clock / pulse monitors
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start === 1'b1) n_start++;
    if (blk_sent === 1'b1) n_sent++;
  end

  // Serve one byte: tx_start is high at the current falling edge. tx_done is
  // returned 5 cycles later; a stray s_tick is thrown in while waiting.
  task automatic serve_byte();
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: tx_byte=%h with no expected byte queued", tx_byte);
      e = tx_byte;
    end else begin
      e = exp_q.pop_front();
      if (tx_byte !== e) begin
        bad++;
        $display("FAIL sb_byte: tx_byte=%h want %h", tx_byte, e);
      end
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      tx_done = 1'b0;
      s_tick  = (c == 2);
      total++;
      if (tx_start !== 1'b0 || tx_byte !== e) begin
        bad++;
        $display("FAIL hold: tx_start=%b tx_byte=%h want 0 %h", tx_start, tx_byte, e);
      end
      if (c == 1) begin
        total++;
        if (blk_ready !== 1'b0 || stat_ready !== 1'b0) begin
          bad++;
          $display("FAIL busy_ready: blk_ready=%b stat_ready=%b want 0 0", blk_ready, stat_ready);
        end
      end
    end
    s_tick  = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // At the falling edge of the cycle after tx_done: check what follows a byte.
  task automatic finish_byte(input bit last, input bit is_blk);
`ifdef UART_TX_SCHED_GAP_EN
    total++;
    if (blk_sent !== (last && is_blk) || tx_start !== 1'b0 || busy !== 1'b1 || state_dbg !== 2'd3) begin
      bad++;
      $display("FAIL gap_entry: blk_sent=%b tx_start=%b busy=%b state=%0d want %b 0 1 3",
               blk_sent, tx_start, busy, state_dbg, last && is_blk);
    end
    for (int k = 0; k < GT; k++) begin
      repeat (9) begin
        @(negedge clk);
        total++;
        if (tx_start !== 1'b0 || busy !== 1'b1 || blk_sent !== 1'b0) begin
          bad++;
          $display("FAIL gap_wait: tx_start=%b busy=%b blk_sent=%b want 0 1 0", tx_start, busy, blk_sent);
        end
      end
      @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
      total++;
      if (k < GT - 1) begin
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL gap_early: tick=%0d tx_start=%b busy=%b want 0 1", k + 1, tx_start, busy);
        end
      end else begin
        if (tx_start !== !last || busy !== !last) begin
          bad++;
          $display("FAIL gap_end: tx_start=%b busy=%b want %b %b", tx_start, busy, !last, !last);
        end
      end
    end
`else
    total++;
    if (tx_start !== !last || blk_sent !== (last && is_blk) || busy !== !last) begin
      bad++;
      $display("FAIL after_done: tx_start=%b blk_sent=%b busy=%b want %b %b %b",
               tx_start, blk_sent, busy, !last, last && is_blk, !last);
    end
`endif
  endtask

  // Valids/data already driven at this falling edge. Checks the grant, queues
  // the expected bytes, then serves n_serve bytes. When n_serve is short of the
  // job length it returns at the falling edge where the next tx_start is high.
  task automatic run_job(input bit exp_blk, input int n_serve, input bit spur, input bit drop);
    int n_total;
    n_total = exp_blk ? NB : 1;
    #1;
    total++;
    if (blk_ready !== exp_blk || stat_ready !== !exp_blk) begin
      bad++;
      $display("FAIL grant: blk_ready=%b stat_ready=%b want %b %b", blk_ready, stat_ready, exp_blk, !exp_blk);
    end
    if (exp_blk) begin
      for (int i = 0; i < NB; i++) exp_q.push_back(blk_data[W-1-8*i -: 8]);
    end else begin
      exp_q.push_back(stat_data);
    end
    exp_starts += (n_serve < n_total) ? n_serve + 1 : n_total;
    @(negedge clk);
    if (drop) begin
      blk_valid  = 1'b0;
      stat_valid = 1'b0;
    end
    if (spur) tx_done = 1'b1;
    total++;
    if (tx_start !== 1'b1 || busy !== 1'b1 || state_dbg !== 2'd1 || blk_ready !== 1'b0 || stat_ready !== 1'b0) begin
      bad++;
      $display("FAIL first_start: tx_start=%b busy=%b state=%0d rdy=%b%b want 1 1 1 00",
               tx_start, busy, state_dbg, blk_ready, stat_ready);
    end
    for (int i = 0; i < n_serve; i++) begin
      serve_byte();
      finish_byte(i == n_total - 1, exp_blk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || tx_byte !== 8'h00 || blk_sent !== 1'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_out: busy=%b tx_start=%b tx_byte=%h blk_sent=%b state=%0d want 0 0 00 0 0",
               busy, tx_start, tx_byte, blk_sent, state_dbg);
    end
    total++;
    if (blk_ready !== 1'b0 || stat_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: blk_ready=%b stat_ready=%b want 0 0", blk_ready, stat_ready);
    end
    // After reset last_grant is block, so status wins a tie.
    blk_valid  = 1'b1;
    stat_valid = 1'b1;
    #1;
    total++;
    if (blk_ready !== 1'b0 || stat_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tie: blk_ready=%b stat_ready=%b want 0 1", blk_ready, stat_ready);
    end
    blk_valid  = 1'b0;
    stat_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    int s0;
    s0 = n_sent;
    for (int i = 0; i < NB; i++) blk_data[W-1-8*i -: 8] = 8'(i);
    blk_valid = 1'b1;
    run_job(1'b1, NB, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || blk_sent !== 1'b0) begin
        bad++;
        $display("FAIL block_idle: busy=%b blk_sent=%b want 0 0", busy, blk_sent);
      end
    end
    total++;
    if (n_sent - s0 !== 1) begin
      bad++;
      $display("FAIL block_sent_count: got %0d want 1", n_sent - s0);
    end
  endtask

  task automatic test_status_only();
    int s0;
    s0 = n_sent;
    stat_data  = 8'hA5;
    stat_valid = 1'b1;
    run_job(1'b0, 1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (n_sent !== s0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL status_end: blk_sent_pulses=%0d busy=%b want 0 0", n_sent - s0, busy);
    end
  endtask

  task automatic test_contention();
    int s0;
    do_reset();
    s0 = n_sent;
    for (int i = 0; i < NB; i++) blk_data[W-1-8*i -: 8] = 8'($urandom_range(0, 255));
    stat_data  = 8'h5A;
    blk_valid  = 1'b1;
    stat_valid = 1'b1;
    run_job(1'b0, 1,  1'b0, 1'b0);
    run_job(1'b1, NB, 1'b0, 1'b0);
    run_job(1'b0, 1,  1'b0, 1'b0);
    run_job(1'b1, NB, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (n_sent - s0 !== 2) begin
      bad++;
      $display("FAIL contention_sent: got %0d want 2", n_sent - s0);
    end
  endtask

  task automatic test_reset_mid_block();
    int s0;
    logic [7:0] e;
    for (int i = 0; i < NB; i++) blk_data[W-1-8*i -: 8] = 8'($urandom_range(0, 255));
    blk_valid = 1'b1;
    run_job(1'b1, 7, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (tx_start !== 1'b1 || tx_byte !== e) begin
      bad++;
      $display("FAIL byte7_start: tx_start=%b tx_byte=%h want 1 %h", tx_start, tx_byte, e);
    end
    s0 = n_sent;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || blk_sent !== 1'b0 || tx_byte !== 8'h00 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b tx_start=%b blk_sent=%b tx_byte=%h state=%0d want 0 0 0 00 0",
               busy, tx_start, blk_sent, tx_byte, state_dbg);
    end
    repeat (4) @(negedge clk);
    total++;
    if (n_sent !== s0) begin
      bad++;
      $display("FAIL mid_reset_sent: got %0d pulses want 0", n_sent - s0);
    end
    for (int i = 0; i < NB; i++) blk_data[W-1-8*i -: 8] = 8'(8'hC0 + i);
    blk_valid = 1'b1;
    run_job(1'b1, NB, 1'b0, 1'b1);
  endtask

  task automatic test_spurious();
    int n0;
    @(negedge clk);
    n0 = n_start;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx_start !== 1'b0 || state_dbg !== 2'd0) begin
        bad++;
        $display("FAIL idle_done: busy=%b tx_start=%b state=%0d want 0 0 0", busy, tx_start, state_dbg);
      end
    end
    total++;
    if (n_start !== n0) begin
      bad++;
      $display("FAIL idle_done_start: got %0d extra starts want 0", n_start - n0);
    end
    // tx_done pulsed during START must not complete the byte.
    stat_data  = 8'h3C;
    stat_valid = 1'b1;
    run_job(1'b0, 1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (n_start !== exp_starts) begin
      bad++;
      $display("FAIL start_count: got %0d want %0d", n_start, exp_starts);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_left: %0d bytes never sent", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_status_only();
    test_contention();
    test_reset_mid_block();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
